melody_scheduler: RTL and testbench

MELODY_SCHEDULER -- requirements
Module: melody_scheduler

---
 rtl/melody_pkg.sv | 26 ++
 rtl/score_rom.sv | 22 ++
 rtl/melody_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_melody_scheduler.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types and constants for the melody scheduler and its score ROM.
package melody_pkg;

  localparam int NOTE_W      = 5;
  localparam int DUR_W       = 3;
  localparam int SCORE_DEPTH = 64;
  localparam int ADDR_W      = $clog2(SCORE_DEPTH);

  localparam logic [NOTE_W-1:0] REST     = '0;
  localparam logic [7:0]        END_MARK = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    PAUSED,
    BEEP
  } melody_state_t;

  // Score word layout: note in the upper five bits, beats-minus-one below.
  function automatic logic [7:0] score_entry(input logic [NOTE_W-1:0] n,
                                             input logic [DUR_W-1:0]  d);
    return {n, d};
  endfunction

endpackage

// File: rtl/score_rom.sv
// 64x8 synchronous score ROM: data appears one clock after addr.
module score_rom
  import melody_pkg::*;
(
  input  logic              sys_CLK,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  function automatic logic [7:0] rom_word(input logic [ADDR_W-1:0] a);
    case (a)
      6'd0:    rom_word = score_entry(5'd3, 3'd1);
      6'd1:    rom_word = score_entry(5'd5, 3'd0);
      default: rom_word = END_MARK;
    endcase
  endfunction

  always_ff @(posedge sys_CLK) begin
    data <= rom_word(addr);
  end

endmodule

// File: rtl/melody_scheduler.sv
// Walks the score ROM beat by beat, driving a tone generator, with pause,
// looping and a one-shot beep that preempts the song without losing its place.
module melody_scheduler
  import melody_pkg::*;
#(
  parameter int BEAT_DIV = 12_500_000,
  parameter int BEEP_CYC = 12_500_000
) (
  input  logic              sys_CLK,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              beep_req,
  input  logic [NOTE_W-1:0] beep_note,
  output logic [NOTE_W-1:0] note,
  output logic              audio_en,
  output logic [ADDR_W-1:0] pos,
  output logic              playing,
  output logic              beep_ack,
  output logic              done
);

  localparam int BEAT_W = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
  localparam int BEEP_W = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYC - 1);

  melody_state_t     state;
  melody_state_t     ret_state;
  logic              fetch_wait;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEEP_W-1:0] beep_cnt;
  logic [3:0]        remaining;
  logic [NOTE_W-1:0] song_note;
  logic [7:0]        rom_data;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              beat_tick;

  score_rom u_score_rom (
    .sys_CLK (sys_CLK),
    .addr    (pos),
    .data    (rom_data)
  );

  assign rom_note  = rom_data[7:3];
  assign rom_dur   = rom_data[2:0];
  assign beat_tick = (beat_cnt == BEAT_LAST);

  // Beep handshake: beep_req is a level sampled every cycle but only honoured
  // in IDLE or PLAY; acceptance is signalled by a single-cycle beep_ack in the
  // first BEEP cycle, and requests seen anywhere else are dropped silently.
  always_ff @(posedge sys_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ret_state  <= IDLE;
      fetch_wait <= 1'b0;
      beat_cnt   <= '0;
      beep_cnt   <= '0;
      remaining  <= '0;
      song_note  <= REST;
      pos        <= '0;
      note       <= REST;
      audio_en   <= 1'b0;
      playing    <= 1'b0;
      beep_ack   <= 1'b0;
      done       <= 1'b0;
    end else begin
      beep_ack <= 1'b0;
      done     <= 1'b0;
      if (stop) begin
        state      <= IDLE;
        fetch_wait <= 1'b0;
        beat_cnt   <= '0;
        beep_cnt   <= '0;
        remaining  <= '0;
        song_note  <= REST;
        pos        <= '0;
        note       <= REST;
        audio_en   <= 1'b0;
        playing    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= FETCH;
              fetch_wait <= 1'b0;
              pos        <= '0;
              beat_cnt   <= '0;
              playing    <= 1'b1;
            end else if (beep_req) begin
              state     <= BEEP;
              ret_state <= IDLE;
              note      <= beep_note;
              audio_en  <= 1'b1;
              beep_ack  <= 1'b1;
              beep_cnt  <= '0;
            end
          end

          // First FETCH cycle addresses the ROM; the second sees its data.
          FETCH: begin
            if (!fetch_wait) begin
              fetch_wait <= 1'b1;
            end else begin
              fetch_wait <= 1'b0;
              if (rom_data == END_MARK) begin
                if (loop_en) begin
                  pos <= '0;
                end else begin
                  state     <= IDLE;
                  done      <= 1'b1;
                  pos       <= '0;
                  song_note <= REST;
                  note      <= REST;
                  audio_en  <= 1'b0;
                  playing   <= 1'b0;
                end
              end else begin
                state     <= PLAY;
                song_note <= rom_note;
                note      <= rom_note;
                audio_en  <= (rom_note != REST);
                remaining <= {1'b0, rom_dur} + 4'd1;
              end
            end
          end

          PLAY: begin
            if (beep_req) begin
              state     <= BEEP;
              ret_state <= PLAY;
              note      <= beep_note;
              audio_en  <= 1'b1;
              beep_ack  <= 1'b1;
              beep_cnt  <= '0;
            end else if (pause) begin
              state    <= PAUSED;
              audio_en <= 1'b0;
            end else if (beat_tick) begin
              beat_cnt <= '0;
              if (remaining == 4'd1) begin
                state      <= FETCH;
                fetch_wait <= 1'b0;
                pos        <= pos + 6'd1;
              end else begin
                remaining <= remaining - 4'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end

          PAUSED: begin
            if (!pause) begin
              state    <= PLAY;
              audio_en <= (song_note != REST);
            end
          end

          // Song note, remaining beats and beat phase are untouched while beeping.
          BEEP: begin
            if (beep_cnt == BEEP_LAST) begin
              state    <= ret_state;
              note     <= (ret_state == PLAY) ? song_note : REST;
              audio_en <= (ret_state == PLAY) && (song_note != REST);
              playing  <= (ret_state == PLAY);
            end else begin
              beep_cnt <= beep_cnt + 1'b1;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_scheduler.sv
// Directed scenarios for melody_scheduler with a note/pulse event scoreboard.
module tb_melody_scheduler;
  import melody_pkg::*;

  localparam int BEAT_DIV = 4;
  localparam int BEEP_CYC = 3;
  localparam logic [3:0] EV_NOTE = 4'd1;
  localparam logic [3:0] EV_ACK  = 4'd2;
  localparam logic [3:0] EV_DONE = 4'd3;

  // ---------------- clock / reset ----------------
  logic              sys_CLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic              loop_en = 1'b0;
  logic              beep_req = 1'b0;
  logic [NOTE_W-1:0] beep_note = '0;
  logic [NOTE_W-1:0] note;
  logic              audio_en;
  logic [ADDR_W-1:0] pos;
  logic              playing;
  logic              beep_ack;
  logic              done;

  always #5 sys_CLK = ~sys_CLK;

  melody_scheduler #(
    .BEAT_DIV (BEAT_DIV),
    .BEEP_CYC (BEEP_CYC)
  ) dut (
    .sys_CLK   (sys_CLK),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .beep_req  (beep_req),
    .beep_note (beep_note),
    .note      (note),
    .audio_en  (audio_en),
    .pos       (pos),
    .playing   (playing),
    .beep_ack  (beep_ack),
    .done      (done)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Event word: kind, note, PLAY-state cycles, total cycles the note was held.
  function automatic logic [31:0] ev(input logic [3:0] k, input logic [7:0] n,
                                     input int p, input int t);
    return {k, n, p[9:0], t[9:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic emit(input logic [31:0] e);
    logic [31:0] x;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL unexpected_event: got %h expected none at %0t", e, $time);
    end else begin
      x = exp_q.pop_front();
      if (e !== x) begin
        n_errors++;
        $display("FAIL event: got %h expected %h at %0t", e, x, $time);
      end
    end
  endtask

  // Monitor: reports each non-rest note run once it ends, plus every pulse cycle.
  logic [NOTE_W-1:0] cur_note = '0;
  int play_cnt = 0;
  int total_cnt = 0;

  initial begin
    forever begin
      @(negedge sys_CLK);
      if (note !== cur_note) begin
        if (cur_note != REST) emit(ev(EV_NOTE, 8'(cur_note), play_cnt, total_cnt));
        cur_note  = note;
        play_cnt  = 0;
        total_cnt = 0;
      end
      total_cnt++;
      if (dut.state == PLAY) play_cnt++;
      if (beep_ack === 1'b1) emit(ev(EV_ACK, 8'd0, 0, 0));
      if (done === 1'b1) emit(ev(EV_DONE, 8'd0, 0, 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge sys_CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    edges(1);
    start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    int k;
    k = 0;
    while (playing !== 1'b0 && k < 100) begin
      edges(1);
      k++;
    end
    @(negedge sys_CLK);
    check({tag, "_playing"}, 32'(playing), 32'd0);
    check({tag, "_note"}, 32'(note), 32'd0);
    check({tag, "_audio_en"}, 32'(audio_en), 32'd0);
    check({tag, "_pos"}, 32'(pos), 32'd0);
    edges(2);
  endtask

  task automatic push_full_song();
    exp_q.push_back(ev(EV_NOTE, 8'd3, 8, 10));
    exp_q.push_back(ev(EV_NOTE, 8'd5, 4, 6));
    exp_q.push_back(ev(EV_DONE, 8'd0, 0, 0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    edges(2);
    @(negedge sys_CLK);
    check("reset_note", 32'(note), 32'd0);
    check("reset_audio_en", 32'(audio_en), 32'd0);
    check("reset_pos", 32'(pos), 32'd0);
    check("reset_playing", 32'(playing), 32'd0);
    check("reset_beep_ack", 32'(beep_ack), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    edges(2);

    // Plain playback: 2 beats of note 3, 1 beat of note 5, end marker.
    push_full_song();
    pulse_start();
    edges(25);
    check_idle("song_end");

    // Looping: after entry 1 the score restarts at 0; stop during the replay.
    loop_en = 1'b1;
    exp_q.push_back(ev(EV_NOTE, 8'd3, 8, 10));
    exp_q.push_back(ev(EV_NOTE, 8'd5, 4, 8));
    exp_q.push_back(ev(EV_NOTE, 8'd3, 4, 4));
    pulse_start();
    edges(21);
    @(negedge sys_CLK);
    check("loop_note", 32'(note), 32'd3);
    check("loop_pos", 32'(pos), 32'd0);
    check("loop_playing", 32'(playing), 32'd1);
    edges(2);
    stop = 1'b1;
    edges(1);
    stop = 1'b0;
    @(negedge sys_CLK);
    check("stop_note", 32'(note), 32'd0);
    check("stop_pos", 32'(pos), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_audio_en", 32'(audio_en), 32'd0);
    loop_en = 1'b0;
    check_idle("after_stop");

    // Five-cycle pause mid-note; a beep request while paused must be ignored.
    exp_q.push_back(ev(EV_NOTE, 8'd3, 9, 16));
    exp_q.push_back(ev(EV_NOTE, 8'd5, 4, 6));
    exp_q.push_back(ev(EV_DONE, 8'd0, 0, 0));
    pulse_start();
    edges(3);
    pause = 1'b1;
    edges(2);
    beep_req  = 1'b1;
    beep_note = 5'd17;
    @(negedge sys_CLK);
    check("pause_audio_en", 32'(audio_en), 32'd0);
    check("pause_note", 32'(note), 32'd3);
    check("pause_pos", 32'(pos), 32'd0);
    check("pause_playing", 32'(playing), 32'd1);
    edges(1);
    beep_req = 1'b0;
    edges(2);
    pause = 1'b0;
    edges(20);
    check_idle("pause_end");

    // Beep during PLAY: note 17 for 3 cycles, then note 3 finishes its beats.
    exp_q.push_back(ev(EV_NOTE, 8'd3, 2, 2));
    exp_q.push_back(ev(EV_ACK, 8'd0, 0, 0));
    exp_q.push_back(ev(EV_NOTE, 8'd17, 0, 3));
    exp_q.push_back(ev(EV_NOTE, 8'd3, 7, 9));
    exp_q.push_back(ev(EV_NOTE, 8'd5, 4, 6));
    exp_q.push_back(ev(EV_DONE, 8'd0, 0, 0));
    pulse_start();
    edges(3);
    beep_req  = 1'b1;
    beep_note = 5'd17;
    edges(1);
    beep_req = 1'b0;
    @(negedge sys_CLK);
    check("beep_note", 32'(note), 32'd17);
    check("beep_audio_en", 32'(audio_en), 32'd1);
    check("beep_playing", 32'(playing), 32'd1);
    edges(20);
    check_idle("beep_end");

    // Beep from IDLE: tone plays but playing stays low, then back to rest.
    exp_q.push_back(ev(EV_ACK, 8'd0, 0, 0));
    exp_q.push_back(ev(EV_NOTE, 8'd17, 0, 3));
    beep_req = 1'b1;
    edges(1);
    beep_req = 1'b0;
    @(negedge sys_CLK);
    check("idle_beep_playing", 32'(playing), 32'd0);
    check("idle_beep_note", 32'(note), 32'd17);
    edges(5);
    check_idle("idle_beep_end");

    // start and stop together: stop wins, nothing starts.
    start = 1'b1;
    stop  = 1'b1;
    edges(1);
    start = 1'b0;
    stop  = 1'b0;
    edges(3);
    check_idle("start_stop");

    // Asynchronous reset mid-note, then a clean replay from entry 0.
    exp_q.push_back(ev(EV_NOTE, 8'd3, 3, 3));
    push_full_song();
    pulse_start();
    edges(4);
    #6;
    rst_n = 1'b0;
    #1;
    check("async_rst_note", 32'(note), 32'd0);
    check("async_rst_audio_en", 32'(audio_en), 32'd0);
    check("async_rst_playing", 32'(playing), 32'd0);
    check("async_rst_pos", 32'(pos), 32'd0);
    edges(2);
    rst_n = 1'b1;
    edges(2);
    pulse_start();
    edges(25);
    check_idle("replay_end");

    edges(4);
    check("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
